oric_sdram_bridge: RTL and testbench

Connects the Oric core's byte-wide RAM bus (chip select, output enable, write enable, address and data) to port 1 of the SDRAM controller, which uses a toggle handshake. Runs in the SDRAM clock domain. The block:
- detects new bus accesses,
- issues toggle requests with the correct byte-lane mask,
- buffers one access while another is in flight,
- returns read data lane-selected and gated by chip select.

It also generates the stretched core reset used when the ROM selection changes.

---
 rtl/oric_pkg.sv | 25 ++
 rtl/oric_reset_stretch.sv | 41 ++++
 rtl/oric_sdram_bridge.sv | 157 +++++++++++++++
 tb/tb_oric_sdram_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/oric_pkg.sv
// Shared types and constants for the Oric RAM bus to SDRAM port bridge.
package oric_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data;
  } mem_op_t;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } bridge_state_t;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_WORD = 2'b11;

  // Byte-lane mask: writes hit one lane chosen by addr[0], reads fetch the word.
  function automatic logic [1:0] op_ds(input mem_op_t op);
    if (op.we) return op.addr[0] ? DS_HI : DS_LO;
    return DS_WORD;
  endfunction

endpackage

// File: rtl/oric_reset_stretch.sv
// Stretched core reset: held for RST_STRETCH cycles after the last of
// reset, ext_reset or a rom_sel change.
module oric_reset_stretch
  import oric_pkg::*;
#(
  parameter int unsigned RST_STRETCH = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ext_reset,
  input  logic rom_sel,
  output logic core_reset
);

  localparam int unsigned CW = $clog2(RST_STRETCH + 1);

  logic [CW-1:0] cnt;
  logic          rom_q;
  logic          cause;

  // Any reset cause, including a change of ROM selection.
  always_comb cause = ext_reset | (rom_sel != rom_q);

  // Reload the counter on any cause, otherwise count down to zero.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rom_q <= rom_sel;
      cnt   <= CW'(RST_STRETCH);
    end else begin
      rom_q <= rom_sel;
      if (cause)
        cnt <= CW'(RST_STRETCH);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  // Core reset stays asserted while the counter is running.
  always_comb core_reset = (cnt != '0);

endmodule

// File: rtl/oric_sdram_bridge.sv
// Oric byte-wide RAM bus to SDRAM port 1 (toggle handshake) bridge, with a
// one-deep pending slot and the stretched core reset.
module oric_sdram_bridge
  import oric_pkg::*;
#(
  parameter int unsigned RST_STRETCH = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ext_reset,
  input  logic        rom_sel,
  input  logic        cpu_cs,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        busy,
  output logic        overrun,
  output logic        core_reset,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic [15:0] sdram_a,
  output logic        sdram_we,
  output logic [1:0]  sdram_ds,
  output logic [15:0] sdram_d,
  input  logic [15:0] sdram_q
);

  bridge_state_t state, state_n;

  logic        cs_q, oe_q, we_q;
  logic [15:0] addr_q;
  logic        trigger;
  mem_op_t     trig_op;

  mem_op_t     pend_op, pend_op_n;
  logic        pend_valid, pend_valid_n;
  logic        overrun_n;
  logic [7:0]  rd_byte, rd_byte_n;
  logic        complete;
  logic        issue;
  mem_op_t     issue_op;

  oric_reset_stretch #(
    .RST_STRETCH(RST_STRETCH)
  ) u_reset_stretch (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ext_reset (ext_reset),
    .rom_sel   (rom_sel),
    .core_reset(core_reset)
  );

  // New bus access: strobe rising edge, or read address changing under oe.
  always_comb begin
    trigger = (cpu_cs & cpu_oe & ~(cs_q & oe_q))
            | (cpu_cs & cpu_we & ~(cs_q & we_q))
            | (cpu_cs & cpu_oe & (cpu_addr != addr_q));
    trig_op = '{addr: cpu_addr, we: cpu_we, data: cpu_din};
  end

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, issue decision, pending slot and read-byte capture.
  // On completion the pending op is issued first; a same-edge trigger
  // then takes the freed slot instead of being dropped.
  always_comb begin
    state_n      = state;
    pend_op_n    = pend_op;
    pend_valid_n = pend_valid;
    overrun_n    = overrun;
    rd_byte_n    = rd_byte;
    issue        = 1'b0;
    issue_op     = trig_op;
    complete     = (state == WAIT_ACK) && (sdram_ack == sdram_req);

    case (state)
      IDLE: begin
        if (trigger) begin
          issue   = 1'b1;
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (complete) begin
          if (!sdram_we)
            rd_byte_n = sdram_a[0] ? sdram_q[15:8] : sdram_q[7:0];
          if (pend_valid) begin
            issue        = 1'b1;
            issue_op     = pend_op;
            pend_valid_n = trigger;
            if (trigger) pend_op_n = trig_op;
          end else if (trigger) begin
            issue = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (trigger) begin
          if (!pend_valid) begin
            pend_valid_n = 1'b1;
            pend_op_n    = trig_op;
          end else begin
            overrun_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus history, SDRAM request outputs and bridge status registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cs_q       <= 1'b0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sdram_req  <= sdram_ack;
      sdram_a    <= '0;
      sdram_we   <= 1'b0;
      sdram_ds   <= DS_WORD;
      sdram_d    <= '0;
      pend_op    <= '0;
      pend_valid <= 1'b0;
      overrun    <= 1'b0;
      rd_byte    <= '0;
    end else begin
      cs_q       <= cpu_cs;
      oe_q       <= cpu_oe;
      we_q       <= cpu_we;
      addr_q     <= cpu_addr;
      pend_op    <= pend_op_n;
      pend_valid <= pend_valid_n;
      overrun    <= overrun_n;
      rd_byte    <= rd_byte_n;
      if (issue) begin
        sdram_req <= ~sdram_req;
        sdram_a   <= issue_op.addr;
        sdram_we  <= issue_op.we;
        sdram_ds  <= op_ds(issue_op);
        sdram_d   <= {issue_op.data, issue_op.data};
      end
    end
  end

  // Read data is gated by the chip select seen at the last edge.
  always_comb begin
    cpu_dout = cs_q ? rd_byte : '0;
    busy     = pend_valid;
  end

endmodule

// File: tb/tb_oric_sdram_bridge.sv
// Directed bench for oric_sdram_bridge with hand-computed expectations.
module tb_oric_sdram_bridge;

  logic        clk_sys = 1'b0;
  logic        reset, ext_reset, rom_sel;
  logic        cpu_cs, cpu_oe, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        busy, overrun, core_reset;
  logic        sdram_req, sdram_ack, sdram_we;
  logic [15:0] sdram_a, sdram_d, sdram_q;
  logic [1:0]  sdram_ds;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned toggles  = 0;
  logic        prev_req = 1'b0;

  oric_sdram_bridge #(
    .RST_STRETCH(16)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ext_reset (ext_reset),
    .rom_sel   (rom_sel),
    .cpu_cs    (cpu_cs),
    .cpu_oe    (cpu_oe),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .busy      (busy),
    .overrun   (overrun),
    .core_reset(core_reset),
    .sdram_req (sdram_req),
    .sdram_ack (sdram_ack),
    .sdram_a   (sdram_a),
    .sdram_we  (sdram_we),
    .sdram_ds  (sdram_ds),
    .sdram_d   (sdram_d),
    .sdram_q   (sdram_q)
  );

  always #5 clk_sys = ~clk_sys;

  // Count every change of the request toggle.
  always @(posedge clk_sys) begin
    if (sdram_req !== prev_req) toggles <= toggles + 1;
    prev_req <= sdram_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic bus_idle();
    cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_we = 1'b0;
  endtask

  int unsigned t0;
  int unsigned high_cnt;
  int unsigned waited;

  initial begin
    reset = 1'b1; ext_reset = 1'b0; rom_sel = 1'b0;
    bus_idle();
    cpu_addr = '0; cpu_din = '0;
    sdram_ack = 1'b0; sdram_q = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_req", 32'(sdram_req), 32'h0);
    check("rst_a", 32'(sdram_a), 32'h0);
    check("rst_we", 32'(sdram_we), 32'h0);
    check("rst_ds", 32'(sdram_ds), 32'h3);
    check("rst_d", 32'(sdram_d), 32'h0);
    check("rst_dout", 32'(cpu_dout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_core_reset", 32'(core_reset), 32'h1);

    waited = 0;
    while (core_reset && waited < 40) begin tick(); waited++; end
    check("core_reset_release", 32'(core_reset), 32'h0);

    // Read 0x1235, ack after 5 cycles
    cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_addr = 16'h1235;
    sdram_q = 16'hAB12;
    tick();
    check("rd_req", 32'(sdram_req), 32'h1);
    check("rd_ds", 32'(sdram_ds), 32'h3);
    check("rd_we", 32'(sdram_we), 32'h0);
    check("rd_a", 32'(sdram_a), 32'h1235);
    repeat (4) tick();
    check("rd_req_hold", 32'(sdram_req), 32'h1);
    sdram_ack = 1'b1;
    tick();
    check("rd_dout", 32'(cpu_dout), 32'hAB);
    check("rd_req_after", 32'(sdram_req), 32'h1);
    bus_idle();
    tick();
    check("rd_dout_cs_low", 32'(cpu_dout), 32'h0);

    // Write 0x5A to 0x2000 then 0x2001
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_din = 8'h5A;
    tick();
    check("wr0_req", 32'(sdram_req), 32'h0);
    check("wr0_we", 32'(sdram_we), 32'h1);
    check("wr0_ds", 32'(sdram_ds), 32'h1);
    check("wr0_d", 32'(sdram_d), 32'h5A5A);
    check("wr0_a", 32'(sdram_a), 32'h2000);
    sdram_ack = 1'b0;
    tick();
    bus_idle();
    tick();
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2001;
    tick();
    check("wr1_req", 32'(sdram_req), 32'h1);
    check("wr1_ds", 32'(sdram_ds), 32'h2);
    check("wr1_d", 32'(sdram_d), 32'h5A5A);
    sdram_ack = 1'b1;
    tick();
    bus_idle();
    tick();

    // Back-to-back: pending slot then overrun
    t0 = toggles;
    cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_addr = 16'h0100;
    tick();
    check("b2b_req_a", 32'(sdram_req), 32'h0);
    check("b2b_busy0", 32'(busy), 32'h0);
    cpu_addr = 16'h0102;
    tick();
    check("b2b_busy1", 32'(busy), 32'h1);
    check("b2b_a_stable", 32'(sdram_a), 32'h0100);
    check("b2b_no_overrun", 32'(overrun), 32'h0);
    cpu_addr = 16'h0104;
    tick();
    check("b2b_overrun", 32'(overrun), 32'h1);
    check("b2b_req_hold", 32'(sdram_req), 32'h0);
    sdram_q = 16'h3344; sdram_ack = 1'b0;
    tick();
    check("b2b_req_b", 32'(sdram_req), 32'h1);
    check("b2b_a_b", 32'(sdram_a), 32'h0102);
    check("b2b_busy_clr", 32'(busy), 32'h0);
    check("b2b_dout_a", 32'(cpu_dout), 32'h44);
    sdram_q = 16'h7788; sdram_ack = 1'b1;
    tick();
    check("b2b_dout_b", 32'(cpu_dout), 32'h88);
    tick(); tick();
    check("b2b_toggles", toggles - t0, 32'd2);
    check("b2b_overrun_sticky", 32'(overrun), 32'h1);
    bus_idle();
    tick();

    // Completion and new trigger on the same edge, slot empty
    cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_addr = 16'h0200;
    tick();
    check("same_req_a", 32'(sdram_req), 32'h0);
    sdram_ack = 1'b0; cpu_addr = 16'h0202;
    tick();
    check("same_req_b", 32'(sdram_req), 32'h1);
    check("same_a_b", 32'(sdram_a), 32'h0202);
    check("same_busy", 32'(busy), 32'h0);
    sdram_ack = 1'b1;
    tick();
    bus_idle();
    tick();
    cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_addr = 16'h0206;
    tick();
    sdram_ack = 1'b0;
    tick();
    bus_idle();
    tick();

    // Reset mid-request while the ack arrives
    cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_addr = 16'h0300;
    tick();
    check("mid_req_out", 32'(sdram_req), 32'h1);
    reset = 1'b1; sdram_ack = 1'b1;
    bus_idle();
    tick(); tick();
    reset = 1'b0;
    tick();
    check("mid_req_after", 32'(sdram_req), 32'h1);
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_overrun_clr", 32'(overrun), 32'h0);
    t0 = toggles;
    repeat (3) tick();
    check("mid_no_spurious", 32'(sdram_req), 32'h1);
    check("mid_toggles", toggles - t0, 32'd0);
    check("mid_dout", 32'(cpu_dout), 32'h0);

    // Bridge works after reset: odd-address read picks upper lane
    cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_addr = 16'h0401;
    tick();
    check("post_req", 32'(sdram_req), 32'h0);
    sdram_q = 16'hCD00; sdram_ack = 1'b0;
    tick();
    check("post_dout", 32'(cpu_dout), 32'hCD);
    bus_idle();
    tick();

    // ROM select change stretches core reset
    waited = 0;
    while (core_reset && waited < 40) begin tick(); waited++; end
    check("rom_pre", 32'(core_reset), 32'h0);
    rom_sel = 1'b1;
    tick();
    check("rom_rise", 32'(core_reset), 32'h1);
    high_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (core_reset) high_cnt++;
      else break;
    end
    check("rom_stretch_len", high_cnt, 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
